// File: rtl/tcore_param.sv
// Shared core parameters: datapath width, CSR op encoding, CSR addresses and mstatus bit positions.
package tcore_param;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;

  // Zicsr read-modify-write result for a given op.
  function automatic logic [XLEN-1:0] csr_new_val(input csr_op_e op,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] wdata);
    case (op)
      CSR_RW:  csr_new_val = wdata;
      CSR_RS:  csr_new_val = old | wdata;
      CSR_RC:  csr_new_val = old & ~wdata;
      default: csr_new_val = old;
    endcase
  endfunction

endpackage

// File: rtl/trap_csr_unit_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  // A write to either half wins over the increment; the other half holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (wr_lo_i) begin
      count_o[31:0] <= wdata_i;
    end else if (wr_hi_i) begin
      count_o[63:32] <= wdata_i;
    end else if (inc_i) begin
      count_o <= count_o + 64'd1;
    end
  end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap/mret sequencer downstream of writeback,
// with Zicsr access and 64-bit mcycle/minstret counters.
module trap_csr_unit
  import tcore_param::*;
#(
  parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_1104,
  parameter logic [XLEN-1:0] HART_ID  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            trap_active_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_mepc_i,
  input  logic            mret_i,
  input  logic            instr_retire_i,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            mie_o
);

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mepc, mcause, mscratch;
  logic [63:0]     mcycle, minstret;

  csr_op_e         op;
  logic [XLEN-1:0] rdata_raw, mstatus_val, wval;
  logic            implemented, wr_attempt, illegal;
  logic            upd_ok, do_trap, do_mret, do_wr;

  assign op = csr_op_e'(csr_op_i);

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE_BIT]  = mie;
    mstatus_val[MSTATUS_MPIE_BIT] = mpie;
    mstatus_val[MSTATUS_MPP_LO +: 2] = 2'b11;
  end

  // Read mux; also flags which addresses exist.
  always_comb begin
    rdata_raw   = '0;
    implemented = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:                 rdata_raw = mstatus_val;
      CSR_MISA:                    rdata_raw = MISA_VAL;
      CSR_MTVEC:                   rdata_raw = mtvec;
      CSR_MSCRATCH:                rdata_raw = mscratch;
      CSR_MEPC:                    rdata_raw = mepc;
      CSR_MCAUSE:                  rdata_raw = mcause;
      CSR_MCYCLE, CSR_CYCLE:       rdata_raw = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     rdata_raw = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata_raw = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_raw = minstret[63:32];
      CSR_MHARTID:                 rdata_raw = HART_ID;
      default:                     implemented = 1'b0;
    endcase
  end

  // RS/RC with a zero mask never writes, so it stays legal on read-only CSRs.
  assign wr_attempt = csr_en_i & ((op == CSR_RW) |
                      (((op == CSR_RS) | (op == CSR_RC)) & (|csr_wdata_i)));
  assign illegal    = csr_en_i & (~implemented | (wr_attempt & (csr_addr_i[11:10] == 2'b11)));
  assign wval       = csr_new_val(op, rdata_raw, csr_wdata_i);

  assign upd_ok  = ~rst_i & ~stall_i;
  assign do_trap = upd_ok & trap_active_i;
  assign do_mret = upd_ok & ~trap_active_i & mret_i;
  assign do_wr   = upd_ok & ~trap_active_i & ~mret_i & wr_attempt & ~illegal;

  assign csr_rdata_o   = (csr_en_i & ~illegal & ~rst_i) ? rdata_raw : '0;
  assign csr_illegal_o = illegal & ~rst_i;
  assign redirect_o    = (trap_active_i | mret_i) & ~rst_i;
  assign redirect_pc_o = trap_active_i ? mtvec : mepc;
  assign mtvec_o       = mtvec;
  assign mie_o         = mie;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
    end else if (do_trap) begin
      mepc   <= trap_mepc_i & ~XLEN'(1);
      mcause <= trap_cause_i;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (do_mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_wr) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mie  <= wval[MSTATUS_MIE_BIT];
          mpie <= wval[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    mtvec    <= wval & ~XLEN'(3);
        CSR_MSCRATCH: mscratch <= wval;
        CSR_MEPC:     mepc     <= wval & ~XLEN'(1);
        CSR_MCAUSE:   mcause   <= wval;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (do_wr & (csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i (do_wr & (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (wval),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instr_retire_i & ~stall_i),
    .wr_lo_i (do_wr & (csr_addr_i == CSR_MINSTRET)),
    .wr_hi_i (do_wr & (csr_addr_i == CSR_MINSTRETH)),
    .wdata_i (wval),
    .count_o (minstret)
  );

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed-vector bench for trap_csr_unit: a driver queues expected responses,
// a negedge monitor pops and compares them.
module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, trap_active_i, mret_i, instr_retire_i, csr_en_i;
  logic [31:0] trap_cause_i, trap_mepc_i, csr_wdata_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_rdata_o, mtvec_o, redirect_pc_o;
  logic        csr_illegal_o, redirect_o, mie_o;

  trap_csr_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .trap_active_i (trap_active_i),
    .trap_cause_i  (trap_cause_i),
    .trap_mepc_i   (trap_mepc_i),
    .mret_i        (mret_i),
    .instr_retire_i(instr_retire_i),
    .csr_en_i      (csr_en_i),
    .csr_op_i      (csr_op_i),
    .csr_addr_i    (csr_addr_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_illegal_o (csr_illegal_o),
    .mtvec_o       (mtvec_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .mie_o         (mie_o)
  );

  always #5 clk = ~clk;

  // mask bits: 0 rdata, 1 illegal, 2 redirect, 3 redirect_pc, 4 mtvec, 5 mie
  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [31:0] rdata;
    logic        ill;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] mtvec;
    logic        mie;
  } exp_t;

  exp_t sb[$];
  logic chk = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic cmp(input string n, input string f, input bit en,
                     input logic [31:0] act, input logic [31:0] exp);
    if (en) begin
      n_vec++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s.%s got %h expected %h", n, f, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL scoreboard_underflow got empty expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.name, "rdata",    e.mask[0], csr_rdata_o, e.rdata);
        cmp(e.name, "illegal",  e.mask[1], 32'(csr_illegal_o), 32'(e.ill));
        cmp(e.name, "redirect", e.mask[2], 32'(redirect_o), 32'(e.redir));
        cmp(e.name, "rpc",      e.mask[3], redirect_pc_o, e.rpc);
        cmp(e.name, "mtvec",    e.mask[4], mtvec_o, e.mtvec);
        cmp(e.name, "mie",      e.mask[5], 32'(mie_o), 32'(e.mie));
      end
    end
  end

  task automatic idle();
    stall_i = 0; trap_active_i = 0; mret_i = 0; instr_retire_i = 0;
    csr_en_i = 0; csr_op_i = 2'b00; csr_addr_i = '0; csr_wdata_i = '0;
    trap_cause_i = '0; trap_mepc_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk = 1'b0;
    idle();
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_en_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
  endtask

  task automatic rd(input logic [11:0] a);
    wr(2'b10, a, 32'h0);
  endtask

  task automatic ex(input string n, input logic [5:0] m, input logic [31:0] rdata,
                    input logic ill, input logic redir, input logic [31:0] rpc,
                    input logic [31:0] mtvec, input logic mie);
    exp_t e;
    e.name = n; e.mask = m; e.rdata = rdata; e.ill = ill; e.redir = redir;
    e.rpc = rpc; e.mtvec = mtvec; e.mie = mie;
    sb.push_back(e);
    chk = 1'b1;
  endtask

  task automatic exr(input string n, input logic [31:0] rdata);
    ex(n, 6'b000111, rdata, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_i = 1;
    step();
    rst_i = 1; trap_active_i = 1; rd(12'h301);
    ex("reset_outputs", 6'b110111, 32'h0, 0, 0, '0, 32'h0, 0); step();
    rst_i = 0;

    rd(12'hB00); exr("mcycle_reset", 32'h0); step();
    rd(12'h300); ex("mstatus_reset", 6'b100111, 32'h0000_1800, 0, 0, '0, '0, 0); step();
    rd(12'h305); ex("mtvec_reset", 6'b010111, 32'h0, 0, 0, '0, 32'h0, 0); step();
    rd(12'h301); exr("misa", 32'h4000_1104); step();
    rd(12'hF14); exr("mhartid", 32'h0); step();
    rd(12'hB80); exr("mcycleh_reset", 32'h0); step();

    wr(2'b01, 12'h305, 32'h8000_0103); exr("mtvec_wr_old", 32'h0); step();
    rd(12'h305); ex("mtvec_rd", 6'b010111, 32'h8000_0100, 0, 0, '0, 32'h8000_0100, 0); step();

    wr(2'b10, 12'h300, 32'h8); exr("mstatus_rs_old", 32'h0000_1800); step();
    rd(12'h300); ex("mie_set", 6'b100111, 32'h0000_1808, 0, 0, '0, '0, 1); step();

    trap_active_i = 1; trap_cause_i = 32'd11; trap_mepc_i = 32'h123;
    ex("trap_redirect", 6'b001100, '0, 0, 1, 32'h8000_0100, '0, 0); step();
    rd(12'h341); exr("trap_mepc", 32'h122); step();
    rd(12'h342); exr("trap_mcause", 32'd11); step();
    rd(12'h300); ex("trap_mstatus", 6'b100111, 32'h0000_1880, 0, 0, '0, '0, 0); step();

    mret_i = 1; ex("mret_redirect", 6'b001100, '0, 0, 1, 32'h122, '0, 0); step();
    rd(12'h300); ex("mret_mstatus", 6'b100111, 32'h0000_1888, 0, 0, '0, '0, 1); step();

    // mcycle low word set to all-ones, then watch the carry into mcycleh
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF); ex("mcycle_wr", 6'b000110, '0, 0, 0, '0, '0, 0); step();
    rd(12'hB00); exr("mcycle_max", 32'hFFFF_FFFF); step();
    rd(12'hB80); exr("mcycleh_carry", 32'h1); step();
    rd(12'hC00); exr("cycle_shadow", 32'h1); step();
    wr(2'b01, 12'hC00, 32'h5); ex("ro_write_illegal", 6'b000111, 32'h0, 1, 0, '0, '0, 0); step();
    rd(12'hC00); exr("cycle_unchanged", 32'h3); step();
    wr(2'b11, 12'hF14, 32'h0); exr("rc_zero_ro_legal", 32'h0); step();
    rd(12'h7C0); ex("unimplemented", 6'b000111, 32'h0, 1, 0, '0, '0, 0); step();
    wr(2'b10, 12'hC80, 32'h1); ex("rs_ro_illegal", 6'b000111, 32'h0, 1, 0, '0, '0, 0); step();

    instr_retire_i = 1; rd(12'hB02); exr("minstret_zero", 32'h0); step();
    instr_retire_i = 1; stall_i = 1; step();
    instr_retire_i = 1; step();
    rd(12'hB02); exr("minstret_count", 32'h2); step();
    instr_retire_i = 1; wr(2'b01, 12'hB02, 32'h10); exr("minstret_wr_old", 32'h2); step();
    rd(12'hC02); exr("minstret_wr_wins", 32'h10); step();
    instr_retire_i = 1; wr(2'b01, 12'hB82, 32'h7); exr("minstreth_wr_old", 32'h0); step();
    rd(12'hB02); exr("minstret_lo_holds", 32'h10); step();
    rd(12'hC82); exr("instreth", 32'h7); step();

    trap_active_i = 1; trap_cause_i = 32'd7; trap_mepc_i = 32'h456; mret_i = 1;
    wr(2'b01, 12'h340, 32'hABCD);
    ex("simul_redirect", 6'b001101, 32'h0, 0, 1, 32'h8000_0100, '0, 0); step();
    rd(12'h340); exr("simul_no_write", 32'h0); step();
    rd(12'h341); exr("simul_mepc", 32'h456); step();
    rd(12'h342); exr("simul_mcause", 32'd7); step();
    rd(12'h300); ex("simul_mstatus", 6'b100111, 32'h0000_1880, 0, 0, '0, '0, 0); step();

    stall_i = 1; trap_active_i = 1; trap_cause_i = 32'd3; trap_mepc_i = 32'h888;
    ex("stall_trap_redirect", 6'b001100, '0, 0, 1, 32'h8000_0100, '0, 0); step();
    rd(12'h341); exr("stall_mepc_hold", 32'h456); step();
    rd(12'h342); exr("stall_mcause_hold", 32'd7); step();
    stall_i = 1; mret_i = 1;
    ex("stall_mret_redirect", 6'b001100, '0, 0, 1, 32'h456, '0, 0); step();
    rd(12'h300); ex("stall_mret_hold", 6'b100111, 32'h0000_1880, 0, 0, '0, '0, 0); step();
    stall_i = 1; wr(2'b01, 12'h340, 32'hFFFF); step();
    rd(12'h340); exr("stall_write_hold", 32'h0); step();

    wr(2'b01, 12'h340, 32'h1234_5678); step();
    rd(12'h340); exr("mscratch_rw", 32'h1234_5678); step();
    wr(2'b11, 12'h340, 32'h78); exr("mscratch_rc_old", 32'h1234_5678); step();
    rd(12'h340); exr("mscratch_rc", 32'h1234_5600); step();
    wr(2'b01, 12'h341, 32'h333); step();
    rd(12'h341); exr("mepc_bit0", 32'h332); step();

    rst_i = 1; trap_active_i = 1; trap_cause_i = 32'd5; trap_mepc_i = 32'h1000;
    wr(2'b01, 12'h340, 32'h1);
    ex("reset_mid", 6'b000111, 32'h0, 0, 0, '0, '0, 0); step();
    rst_i = 0;
    rd(12'h341); exr("reset_mepc", 32'h0); step();
    rd(12'h340); exr("reset_mscratch", 32'h0); step();
    rd(12'h305); ex("reset_mtvec", 6'b010111, 32'h0, 0, 0, '0, 32'h0, 0); step();
    rd(12'h300); ex("reset_mstatus", 6'b100111, 32'h0000_1800, 0, 0, '0, '0, 0); step();

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
